mcu0_intc: RTL and testbench

Interrupt controller that drives the MCU0 core's `interrupt`/`irq[2:0]` request inputs. It collects 8 peripheral request lines and synchronizes them. It latches each line as edge- or level-triggered pending, applies an enable mask and resolves fixed priority. It then handshakes with the core: the core pulses `ack` when it enters the ISR and `eoi` when it executes IRET. The block sits between the peripherals and the cpu module's interrupt inputs.

---
 rtl/mcu0_intc_if.sv | 27 ++
 rtl/mcu0_intc.sv | 97 +++++++++
 tb/tb_mcu0_intc.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mcu0_intc_if.sv
// mcu0_intc bus bundle: peripheral requests, enable
// register access and the core interrupt handshake.
interface mcu0_intc_if #(
    parameter int NUM_SRC = 8,
    parameter int IRQ_W   = 3
);
    logic [NUM_SRC-1:0] src;
    logic               mask_we;
    logic [NUM_SRC-1:0] mask_wdata;
    logic [NUM_SRC-1:0] enable;
    logic [NUM_SRC-1:0] pending;
    logic               interrupt;
    logic [IRQ_W-1:0]   irq;
    logic               ack;
    logic               eoi;
    logic               in_service;

    modport master (
        output src, mask_we, mask_wdata, ack, eoi,
        input  enable, pending, interrupt, irq, in_service
    );

    modport slave (
        input  src, mask_we, mask_wdata, ack, eoi,
        output enable, pending, interrupt, irq, in_service
    );
endinterface

// File: rtl/mcu0_intc.sv
// mcu0_intc: 8-source fixed-priority interrupt
// controller with ack/eoi handshake to the MCU0 core.
module mcu0_intc #(
    parameter int NUM_SRC = 8,
    parameter int IRQ_W   = 3,
    parameter logic [NUM_SRC-1:0] EDGE_MASK = {NUM_SRC{1'b1}}
) (
    input logic        clock,
    input logic        reset_n,
    mcu0_intc_if.slave bus
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] REQ     = 2'd1;
    localparam logic [1:0] SERVICE = 2'd2;

    logic [1:0]         state;
    logic [NUM_SRC-1:0] s1, s2, s3;
    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] clr;
    logic [NUM_SRC-1:0] pend;
    logic [NUM_SRC-1:0] en;
    logic [NUM_SRC-1:0] eligible;
    logic [IRQ_W-1:0]   win;
    logic [IRQ_W-1:0]   irq_q;
    logic               take;

    assign req      = (s2 & ~s3 & EDGE_MASK) | (s2 & ~EDGE_MASK);
    assign eligible = pend & en;
    assign take     = (state == REQ) && bus.ack;

    // Lowest index wins; clear vector targets the vector being acked.
    always_comb begin
        win = '0;
        clr = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) win = IRQ_W'(i);
            if (take && irq_q == IRQ_W'(i)) clr[i] = 1'b1;
        end
    end

    // Two-flop synchronizer plus a delayed copy for edge detection.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= bus.src;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Pending bits: a new request beats a same-edge ack clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) pend <= '0;
        else          pend <= (pend & ~clr) | req;
    end

    // Enable register write.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)         en <= '0;
        else if (bus.mask_we) en <= bus.mask_wdata;
    end

    // Handshake FSM; vector frozen outside IDLE.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            irq_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|eligible) begin
                        irq_q <= win;
                        state <= REQ;
                    end else begin
                        irq_q <= '0;
                    end
                end
                REQ: begin
                    if (bus.ack) state <= SERVICE;
                end
                SERVICE: begin
                    if (bus.eoi) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.enable     = en;
    assign bus.pending    = pend;
    assign bus.irq        = irq_q;
    assign bus.interrupt  = (state == REQ);
    assign bus.in_service = (state == SERVICE);
endmodule

// File: tb/tb_mcu0_intc.sv
// Directed self-checking bench for mcu0_intc,
// one edge-mode instance and one with a level source 0.
module tb_mcu0_intc;
    logic clock;
    logic reset_n;
    int   total;
    int   bad;

    mcu0_intc_if #(.NUM_SRC(8), .IRQ_W(3)) bus ();
    mcu0_intc_if #(.NUM_SRC(8), .IRQ_W(3)) lv ();

    mcu0_intc #(.NUM_SRC(8), .IRQ_W(3), .EDGE_MASK(8'hFF)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    mcu0_intc #(.NUM_SRC(8), .IRQ_W(3), .EDGE_MASK(8'hFE)) dut_lv (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (lv.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_ack();
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
    endtask

    task automatic pulse_eoi();
        bus.eoi = 1'b1;
        tick();
        bus.eoi = 1'b0;
    endtask

    task automatic write_en(input logic [7:0] v);
        bus.mask_we    = 1'b1;
        bus.mask_wdata = v;
        tick();
        bus.mask_we    = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #2;
        total++;
        if (bus.pending !== 8'h00 || bus.enable !== 8'h00 ||
            bus.interrupt !== 1'b0 || bus.irq !== 3'd0 ||
            bus.in_service !== 1'b0) begin
            $display("FAIL reset_outputs got p=%h e=%h i=%b q=%0d s=%b want 0",
                     bus.pending, bus.enable, bus.interrupt,
                     bus.irq, bus.in_service);
            bad++;
        end
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        write_en(8'hFF);
        bus.src = 8'h04;
        tick();
        tick();
        total++;
        if (bus.pending !== 8'h00) begin
            $display("FAIL basic_pend_e2 got=%h want=00", bus.pending);
            bad++;
        end
        tick();
        bus.src = 8'h00;
        total++;
        if (bus.pending !== 8'h04 || bus.interrupt !== 1'b0) begin
            $display("FAIL basic_pend_e3 got p=%h i=%b want p=04 i=0",
                     bus.pending, bus.interrupt);
            bad++;
        end
        tick();
        total++;
        if (bus.interrupt !== 1'b1 || bus.irq !== 3'd2) begin
            $display("FAIL basic_req_e4 got i=%b q=%0d want i=1 q=2",
                     bus.interrupt, bus.irq);
            bad++;
        end
        tick();
        tick();
        total++;
        if (bus.interrupt !== 1'b1) begin
            $display("FAIL basic_hold got=%b want=1", bus.interrupt);
            bad++;
        end
        pulse_ack();
        total++;
        if (bus.pending !== 8'h00 || bus.interrupt !== 1'b0 ||
            bus.in_service !== 1'b1 || bus.irq !== 3'd2) begin
            $display("FAIL basic_ack got p=%h i=%b s=%b q=%0d want 00 0 1 2",
                     bus.pending, bus.interrupt, bus.in_service, bus.irq);
            bad++;
        end
        pulse_eoi();
        total++;
        if (bus.in_service !== 1'b0 || bus.interrupt !== 1'b0) begin
            $display("FAIL basic_eoi got s=%b i=%b want 0 0",
                     bus.in_service, bus.interrupt);
            bad++;
        end
        tick();
        total++;
        if (bus.irq !== 3'd0) begin
            $display("FAIL basic_irq_idle got=%0d want=0", bus.irq);
            bad++;
        end
    endtask

    task automatic test_priority();
        bus.src = 8'h22;
        tick();
        tick();
        tick();
        bus.src = 8'h00;
        tick();
        total++;
        if (bus.interrupt !== 1'b1 || bus.irq !== 3'd1 ||
            bus.pending !== 8'h22) begin
            $display("FAIL prio_first got i=%b q=%0d p=%h want 1 1 22",
                     bus.interrupt, bus.irq, bus.pending);
            bad++;
        end
        bus.src = 8'h01;
        tick();
        tick();
        tick();
        bus.src = 8'h00;
        tick();
        total++;
        if (bus.irq !== 3'd1 || bus.pending !== 8'h23 ||
            bus.interrupt !== 1'b1) begin
            $display("FAIL prio_frozen got q=%0d p=%h i=%b want 1 23 1",
                     bus.irq, bus.pending, bus.interrupt);
            bad++;
        end
        pulse_ack();
        total++;
        if (bus.pending !== 8'h21 || bus.in_service !== 1'b1) begin
            $display("FAIL prio_ack got p=%h s=%b want 21 1",
                     bus.pending, bus.in_service);
            bad++;
        end
        pulse_eoi();
        tick();
        total++;
        if (bus.interrupt !== 1'b1 || bus.irq !== 3'd0) begin
            $display("FAIL prio_second got i=%b q=%0d want 1 0",
                     bus.interrupt, bus.irq);
            bad++;
        end
        pulse_ack();
        pulse_eoi();
        tick();
        total++;
        if (bus.interrupt !== 1'b1 || bus.irq !== 3'd5) begin
            $display("FAIL prio_third got i=%b q=%0d want 1 5",
                     bus.interrupt, bus.irq);
            bad++;
        end
        pulse_ack();
        pulse_eoi();
        total++;
        if (bus.pending !== 8'h00) begin
            $display("FAIL prio_drain got=%h want=00", bus.pending);
            bad++;
        end
    endtask

    task automatic test_mask();
        bit seen;
        write_en(8'h00);
        bus.src = 8'h08;
        tick();
        tick();
        tick();
        bus.src = 8'h00;
        total++;
        if (bus.pending !== 8'h08) begin
            $display("FAIL mask_pend got=%h want=08", bus.pending);
            bad++;
        end
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.interrupt !== 1'b0) seen = 1'b1;
        end
        total++;
        if (seen) begin
            $display("FAIL mask_quiet got=1 want=0");
            bad++;
        end
        write_en(8'h08);
        total++;
        if (bus.enable !== 8'h08 || bus.interrupt !== 1'b0) begin
            $display("FAIL mask_write got e=%h i=%b want 08 0",
                     bus.enable, bus.interrupt);
            bad++;
        end
        tick();
        total++;
        if (bus.interrupt !== 1'b1 || bus.irq !== 3'd3) begin
            $display("FAIL mask_req got i=%b q=%0d want 1 3",
                     bus.interrupt, bus.irq);
            bad++;
        end
        pulse_ack();
        pulse_eoi();
        write_en(8'hFF);
    endtask

    task automatic test_level();
        lv.mask_we    = 1'b1;
        lv.mask_wdata = 8'h01;
        tick();
        lv.mask_we = 1'b0;
        lv.src     = 8'h01;
        tick();
        tick();
        tick();
        tick();
        total++;
        if (lv.interrupt !== 1'b1 || lv.irq !== 3'd0) begin
            $display("FAIL level_req got i=%b q=%0d want 1 0",
                     lv.interrupt, lv.irq);
            bad++;
        end
        lv.ack = 1'b1;
        tick();
        lv.ack = 1'b0;
        total++;
        if (lv.in_service !== 1'b1 || lv.pending !== 8'h01) begin
            $display("FAIL level_repend got s=%b p=%h want 1 01",
                     lv.in_service, lv.pending);
            bad++;
        end
        lv.eoi = 1'b1;
        tick();
        lv.eoi = 1'b0;
        total++;
        if (lv.interrupt !== 1'b0 || lv.in_service !== 1'b0) begin
            $display("FAIL level_idle got i=%b s=%b want 0 0",
                     lv.interrupt, lv.in_service);
            bad++;
        end
        tick();
        total++;
        if (lv.interrupt !== 1'b1 || lv.irq !== 3'd0) begin
            $display("FAIL level_again got i=%b q=%0d want 1 0",
                     lv.interrupt, lv.irq);
            bad++;
        end
        lv.src = 8'h00;
        tick();
        tick();
        tick();
        lv.ack = 1'b1;
        tick();
        lv.ack = 1'b0;
        total++;
        if (lv.pending !== 8'h00) begin
            $display("FAIL level_release got=%h want=00", lv.pending);
            bad++;
        end
        lv.eoi = 1'b1;
        tick();
        lv.eoi = 1'b0;
    endtask

    task automatic test_ignored();
        pulse_ack();
        total++;
        if (bus.interrupt !== 1'b0 || bus.in_service !== 1'b0) begin
            $display("FAIL ign_ack_idle got i=%b s=%b want 0 0",
                     bus.interrupt, bus.in_service);
            bad++;
        end
        bus.src = 8'h04;
        tick();
        bus.src = 8'h00;
        tick();
        tick();
        tick();
        pulse_eoi();
        total++;
        if (bus.interrupt !== 1'b1 || bus.in_service !== 1'b0 ||
            bus.irq !== 3'd2) begin
            $display("FAIL ign_eoi_req got i=%b s=%b q=%0d want 1 0 2",
                     bus.interrupt, bus.in_service, bus.irq);
            bad++;
        end
        bus.src = 8'h04;
        tick();
        tick();
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        bus.src = 8'h00;
        total++;
        if (bus.in_service !== 1'b1 || bus.pending !== 8'h04) begin
            $display("FAIL ign_set_wins got s=%b p=%h want 1 04",
                     bus.in_service, bus.pending);
            bad++;
        end
        pulse_ack();
        total++;
        if (bus.in_service !== 1'b1 || bus.pending !== 8'h04) begin
            $display("FAIL ign_ack_svc got s=%b p=%h want 1 04",
                     bus.in_service, bus.pending);
            bad++;
        end
        pulse_eoi();
        tick();
        total++;
        if (bus.interrupt !== 1'b1 || bus.irq !== 3'd2) begin
            $display("FAIL ign_repeat got i=%b q=%0d want 1 2",
                     bus.interrupt, bus.irq);
            bad++;
        end
        bus.ack = 1'b1;
        bus.eoi = 1'b1;
        tick();
        bus.ack = 1'b0;
        bus.eoi = 1'b0;
        total++;
        if (bus.in_service !== 1'b1 || bus.interrupt !== 1'b0) begin
            $display("FAIL ign_ack_eoi got s=%b i=%b want 1 0",
                     bus.in_service, bus.interrupt);
            bad++;
        end
        pulse_eoi();
        total++;
        if (bus.in_service !== 1'b0 || bus.pending !== 8'h00) begin
            $display("FAIL ign_done got s=%b p=%h want 0 00",
                     bus.in_service, bus.pending);
            bad++;
        end
    endtask

    task automatic test_reset_mid();
        bus.src = 8'h02;
        tick();
        bus.src = 8'h00;
        tick();
        tick();
        tick();
        pulse_ack();
        bus.src = 8'h10;
        tick();
        tick();
        tick();
        total++;
        if (bus.in_service !== 1'b1 || bus.pending !== 8'h10) begin
            $display("FAIL rmid_setup got s=%b p=%h want 1 10",
                     bus.in_service, bus.pending);
            bad++;
        end
        #3;
        reset_n = 1'b0;
        #1;
        total++;
        if (bus.pending !== 8'h00 || bus.enable !== 8'h00 ||
            bus.interrupt !== 1'b0 || bus.irq !== 3'd0 ||
            bus.in_service !== 1'b0) begin
            $display("FAIL rmid_async got p=%h e=%h i=%b q=%0d s=%b want 0",
                     bus.pending, bus.enable, bus.interrupt,
                     bus.irq, bus.in_service);
            bad++;
        end
        @(posedge clock);
        #1;
        reset_n        = 1'b1;
        bus.mask_we    = 1'b1;
        bus.mask_wdata = 8'hFF;
        tick();
        bus.mask_we = 1'b0;
        tick();
        tick();
        total++;
        if (bus.pending !== 8'h10 || bus.interrupt !== 1'b0) begin
            $display("FAIL rmid_e3 got p=%h i=%b want 10 0",
                     bus.pending, bus.interrupt);
            bad++;
        end
        tick();
        total++;
        if (bus.interrupt !== 1'b1 || bus.irq !== 3'd4) begin
            $display("FAIL rmid_e4 got i=%b q=%0d want 1 4",
                     bus.interrupt, bus.irq);
            bad++;
        end
        bus.src = 8'h00;
        pulse_ack();
        pulse_eoi();
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        reset_n        = 1'b0;
        bus.src        = '0;
        bus.mask_we    = 1'b0;
        bus.mask_wdata = '0;
        bus.ack        = 1'b0;
        bus.eoi        = 1'b0;
        lv.src         = '0;
        lv.mask_we     = 1'b0;
        lv.mask_wdata  = '0;
        lv.ack         = 1'b0;
        lv.eoi         = 1'b0;
        test_reset();
        test_basic();
        test_priority();
        test_mask();
        test_level();
        test_ignored();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
